quad_paddle_ctrl: RTL and testbench

Parametrised N-channel quadrature-encoder paddle controller. Each channel synchronises and deglitches an A/B encoder pair, decodes x4 Gray transitions, divides counts into paddle steps and maintains a clamped paddle position. It sits between the player encoder pins and the game/render logic, and generalises the two-paddle movement block with these additions: channel count, filter, step divider, direction invert, illegal-transition flags and step pulses.

---
 rtl/quad_paddle_ctrl.sv | 163 ++++++++++++++++
 tb/tb_quad_paddle_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : quad_paddle_ctrl
// Brief    : N-channel quadrature encoder front end driving clamped paddle
//            positions with step pulses and sticky illegal-transition flags.
// Revision : 1.0 - initial release
// ============================================================================
module quad_paddle_ctrl #(
    parameter int                NUM_CH       = 2,
    parameter int                POS_W        = 6,
    parameter int                POS_MIN      = 5,
    parameter int                POS_MAX      = 58,
    parameter int                POS_INIT     = 28,
    parameter int                CNT_PER_STEP = 4,
    parameter int                FILT_LEN     = 3,
    parameter logic [NUM_CH-1:0] INVERT       = {NUM_CH{1'b0}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enca,
    input  logic [NUM_CH-1:0]       encb,
    input  logic                    reset_game,
    input  logic                    clr_err,
    output logic [NUM_CH*POS_W-1:0] pos,
    output logic [NUM_CH-1:0]       step_up,
    output logic [NUM_CH-1:0]       step_dn,
    output logic [NUM_CH-1:0]       err
);

    localparam int                        c_stab_w   = 4;
    localparam int                        c_sub_w    = 5;
    localparam logic [c_stab_w-1:0]       c_filt     = c_stab_w'(FILT_LEN);
    localparam logic [c_stab_w-1:0]       c_stab_max = '1;
    localparam logic [c_stab_w-1:0]       c_stab_one = c_stab_w'(1);
    localparam logic signed [c_sub_w-1:0] c_sub_top  = c_sub_w'(CNT_PER_STEP - 1);
    localparam logic signed [c_sub_w-1:0] c_sub_bot  = -c_sub_top;
    localparam logic signed [c_sub_w-1:0] c_sub_one  = c_sub_w'(1);
    localparam logic [POS_W-1:0]          c_pos_min  = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0]          c_pos_max  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0]          c_pos_init = POS_W'(POS_INIT);
    localparam logic [POS_W-1:0]          c_pos_one  = POS_W'(1);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [1:0]                  r_sync1;
        logic [1:0]                  r_sync2;
        logic [1:0]                  r_prev;
        logic [1:0]                  r_fill;
        logic [c_stab_w-1:0]         r_stab;
        logic [1:0]                  r_ab_f;
        logic                        r_primed;
        logic                        r_ev_up;
        logic                        r_ev_dn;
        logic                        r_ev_ill;
        logic signed [c_sub_w-1:0]   r_sub;
        logic [POS_W-1:0]            r_pos;
        logic                        r_step_up;
        logic                        r_step_dn;
        logic                        r_err;

        logic [c_stab_w-1:0]         w_stab_nxt;
        logic                        w_accept;
        logic [1:0]                  w_delta;
        logic                        w_up;
        logic                        w_dn;
        logic                        w_ill;

        always_comb begin
            if (r_sync2 != r_prev) begin
                w_stab_nxt = c_stab_one;
            end else if (r_stab == c_stab_max) begin
                w_stab_nxt = r_stab;
            end else begin
                w_stab_nxt = r_stab + c_stab_one;
            end
            // r_fill keeps reset-flushed synchroniser zeros from priming ab_f
            w_accept = r_fill[1] && (w_stab_nxt >= c_filt) &&
                       (!r_primed || (r_sync2 != r_ab_f));
            // Gray code to position index: 00->0, 01->1, 11->2, 10->3
            w_delta  = {r_sync2[1], ^r_sync2} - {r_ab_f[1], ^r_ab_f};
            w_ill    = (w_delta == 2'd2);
            w_up     = INVERT[gi] ? (w_delta == 2'd3) : (w_delta == 2'd1);
            w_dn     = INVERT[gi] ? (w_delta == 2'd1) : (w_delta == 2'd3);
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync1  <= '0;
                r_sync2  <= '0;
                r_prev   <= '0;
                r_fill   <= '0;
                r_stab   <= '0;
                r_ab_f   <= '0;
                r_primed <= 1'b0;
                r_ev_up  <= 1'b0;
                r_ev_dn  <= 1'b0;
                r_ev_ill <= 1'b0;
            end else begin
                r_sync1  <= {enca[gi], encb[gi]};
                r_sync2  <= r_sync1;
                r_prev   <= r_sync2;
                r_fill   <= {r_fill[0], 1'b1};
                r_stab   <= w_stab_nxt;
                r_ev_up  <= 1'b0;
                r_ev_dn  <= 1'b0;
                r_ev_ill <= 1'b0;
                if (w_accept) begin
                    r_ab_f   <= r_sync2;
                    r_primed <= 1'b1;
                    if (r_primed) begin
                        r_ev_up  <= w_up;
                        r_ev_dn  <= w_dn;
                        r_ev_ill <= w_ill;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sub     <= '0;
                r_pos     <= c_pos_init;
                r_step_up <= 1'b0;
                r_step_dn <= 1'b0;
                r_err     <= 1'b0;
            end else begin
                r_step_up <= 1'b0;
                r_step_dn <= 1'b0;
                r_err     <= (r_err & ~clr_err) | r_ev_ill;
                if (reset_game) begin
                    r_sub <= '0;
                    r_pos <= c_pos_init;
                end else if (r_ev_up) begin
                    if (r_sub == c_sub_top) begin
                        r_sub <= '0;
                        if (r_pos < c_pos_max) begin
                            r_pos     <= r_pos + c_pos_one;
                            r_step_up <= 1'b1;
                        end
                    end else begin
                        r_sub <= r_sub + c_sub_one;
                    end
                end else if (r_ev_dn) begin
                    if (r_sub == c_sub_bot) begin
                        r_sub <= '0;
                        if (r_pos > c_pos_min) begin
                            r_pos     <= r_pos - c_pos_one;
                            r_step_dn <= 1'b1;
                        end
                    end else begin
                        r_sub <= r_sub - c_sub_one;
                    end
                end
            end
        end

        assign pos[gi*POS_W +: POS_W] = r_pos;
        assign step_up[gi]            = r_step_up;
        assign step_dn[gi]            = r_step_dn;
        assign err[gi]                = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_paddle_ctrl
// Brief    : Scoreboard bench for quad_paddle_ctrl; two instances share pins
//            (default config, and INVERT=01 with one count per step).
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_paddle_ctrl;

    localparam int c_init = 28;
    localparam int c_min  = 5;
    localparam int c_max  = 58;
    localparam int c_filt = 3;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic [1:0]  enca       = 2'b00;
    logic [1:0]  encb       = 2'b00;
    logic        reset_game = 1'b0;
    logic        clr_err    = 1'b0;
    logic [11:0] pos_a, pos_b;
    logic [1:0]  up_a, dn_a, err_a, up_b, dn_b, err_b;

    always #5 clk = ~clk;

    quad_paddle_ctrl #(
        .NUM_CH(2), .POS_W(6), .POS_MIN(5), .POS_MAX(58), .POS_INIT(28),
        .CNT_PER_STEP(4), .FILT_LEN(3), .INVERT(2'b00)
    ) dut_a (
        .clk(clk), .reset(reset), .enca(enca), .encb(encb),
        .reset_game(reset_game), .clr_err(clr_err),
        .pos(pos_a), .step_up(up_a), .step_dn(dn_a), .err(err_a)
    );

    quad_paddle_ctrl #(
        .NUM_CH(2), .POS_W(6), .POS_MIN(5), .POS_MAX(58), .POS_INIT(28),
        .CNT_PER_STEP(1), .FILT_LEN(3), .INVERT(2'b01)
    ) dut_b (
        .clk(clk), .reset(reset), .enca(enca), .encb(encb),
        .reset_game(reset_game), .clr_err(clr_err),
        .pos(pos_b), .step_up(up_b), .step_dn(dn_b), .err(err_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, indexed [instance][channel]
    logic [1:0] c_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int         m_cnt [2]    = '{4, 1};
    int         m_inv [2][2] = '{'{0, 0}, '{1, 0}};
    int         m_primed [2][2];
    logic [1:0] m_abf [2][2];
    int         m_sub [2][2];
    int         m_pos [2][2];
    int         m_err [2][2];
    logic [1:0] cur [2];

    typedef struct { int k; int ch; int dir; int p; } ev_t;
    ev_t evq[$];
    int  npulse [2][2][2];
    int  mon_found;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int get_pos(input int k, input int ch);
        logic [11:0] p;
        p = (k == 0) ? pos_a : pos_b;
        return int'(p[ch*6 +: 6]);
    endfunction

    function automatic int get_up(input int k, input int ch);
        return (k == 0) ? int'(up_a[ch]) : int'(up_b[ch]);
    endfunction

    function automatic int get_dn(input int k, input int ch);
        return (k == 0) ? int'(dn_a[ch]) : int'(dn_b[ch]);
    endfunction

    function automatic int get_err(input int k, input int ch);
        return (k == 0) ? int'(err_a[ch]) : int'(err_b[ch]);
    endfunction

    function automatic int seq_idx(input logic [1:0] v);
        for (int i = 0; i < 4; i++) if (c_seq[i] == v) return i;
        return 0;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++)
            for (int ch = 0; ch < 2; ch++) begin
                m_primed[k][ch] = 0;
                m_abf[k][ch]    = 2'b00;
                m_sub[k][ch]    = 0;
                m_pos[k][ch]    = c_init;
                m_err[k][ch]    = 0;
            end
        evq.delete();
    endfunction

    function automatic void model_rg();
        for (int k = 0; k < 2; k++)
            for (int ch = 0; ch < 2; ch++) begin
                m_sub[k][ch] = 0;
                m_pos[k][ch] = c_init;
            end
    endfunction

    // A pin value held long enough has been accepted by the filter
    function automatic void model_accept(input int k, input int ch, input logic [1:0] v, input bit discard);
        int ia, d;
        ev_t e;
        if (m_primed[k][ch] == 0) begin
            m_primed[k][ch] = 1;
            m_abf[k][ch]    = v;
            return;
        end
        if (v == m_abf[k][ch]) return;
        ia = seq_idx(m_abf[k][ch]);
        if (v == c_seq[(ia + 1) % 4])      d = 1;
        else if (v == c_seq[(ia + 3) % 4]) d = -1;
        else                               d = 0;
        m_abf[k][ch] = v;
        if (d == 0) begin
            m_err[k][ch] = 1;
            return;
        end
        if (m_inv[k][ch] != 0) d = -d;
        if (discard) return;
        m_sub[k][ch] += d;
        if (m_sub[k][ch] == m_cnt[k] || m_sub[k][ch] == -m_cnt[k]) begin
            m_sub[k][ch] = 0;
            if ((d > 0 && m_pos[k][ch] < c_max) || (d < 0 && m_pos[k][ch] > c_min)) begin
                m_pos[k][ch] += d;
                e.k = k; e.ch = ch; e.dir = d; e.p = m_pos[k][ch];
                evq.push_back(e);
            end
        end
    endfunction

    // Monitor: every step pulse must match the oldest expected event of its channel
    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++)
                for (int ch = 0; ch < 2; ch++) begin
                    if (get_up(k, ch) != 0 || get_dn(k, ch) != 0) begin
                        if (get_up(k, ch) != 0) npulse[k][ch][0]++;
                        if (get_dn(k, ch) != 0) npulse[k][ch][1]++;
                        mon_found = -1;
                        for (int i = 0; i < evq.size(); i++)
                            if (mon_found < 0 && evq[i].k == k && evq[i].ch == ch) mon_found = i;
                        if (mon_found < 0) begin
                            chk($sformatf("unexpected_pulse_k%0d_ch%0d", k, ch), 1, 0);
                        end else begin
                            chk($sformatf("pulse_dir_k%0d_ch%0d", k, ch),
                                get_up(k, ch) - get_dn(k, ch), evq[mon_found].dir);
                            chk($sformatf("pulse_pos_k%0d_ch%0d", k, ch),
                                get_pos(k, ch), evq[mon_found].p);
                            evq.delete(mon_found);
                        end
                    end
                end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pins(input int ch, input logic [1:0] v);
        enca[ch] = v[1];
        encb[ch] = v[0];
        cur[ch]  = v;
    endtask

    task automatic step_pins(input int ch, input logic [1:0] v, input int hold);
        set_pins(ch, v);
        if (hold >= c_filt)
            for (int k = 0; k < 2; k++) model_accept(k, ch, v, 1'b0);
        tick(hold);
    endtask

    function automatic logic [1:0] next_val(input int ch, input int dir);
        return c_seq[(seq_idx(cur[ch]) + dir + 4) % 4];
    endfunction

    task automatic count(input int ch, input int dir, input int n, input int hold);
        for (int i = 0; i < n; i++) step_pins(ch, next_val(ch, dir), hold);
    endtask

    task automatic glitch(input int ch, input logic [1:0] v, input int w);
        logic [1:0] old;
        old = cur[ch];
        set_pins(ch, v);
        tick(w);
        set_pins(ch, old);
        tick(8);
    endtask

    task automatic check_all(input string tag);
        tick(c_filt + 6);
        for (int k = 0; k < 2; k++)
            for (int ch = 0; ch < 2; ch++) begin
                chk($sformatf("%s_pos_k%0d_ch%0d", tag, k, ch), get_pos(k, ch), m_pos[k][ch]);
                chk($sformatf("%s_err_k%0d_ch%0d", tag, k, ch), get_err(k, ch), m_err[k][ch]);
            end
        chk($sformatf("%s_pending_events", tag), evq.size(), 0);
    endtask

    task automatic do_reset(input logic [1:0] v);
        set_pins(0, v);
        set_pins(1, v);
        #2 reset = 1'b0;
        model_reset();
        tick(3);
        reset = 1'b1;
        tick(10);
        for (int k = 0; k < 2; k++)
            for (int ch = 0; ch < 2; ch++) model_accept(k, ch, cur[ch], 1'b0);
    endtask

    function automatic int total_pulses();
        int s = 0;
        for (int k = 0; k < 2; k++)
            for (int ch = 0; ch < 2; ch++) s += npulse[k][ch][0] + npulse[k][ch][1];
        return s;
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] nv;
        int snap, snap2, ch, r;

        cur[0] = 2'b00;
        cur[1] = 2'b00;
        model_reset();
        tick(3);
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 2; c++) begin
                chk("rst_pos", get_pos(k, c), c_init);
                chk("rst_err", get_err(k, c), 0);
                chk("rst_step", get_up(k, c) + get_dn(k, c), 0);
            end
        reset = 1'b1;
        tick(10);
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 2; c++) model_accept(k, c, cur[c], 1'b0);

        // Four forward counts on ch0 with a latency probe on the fourth
        count(0, 1, 3, 10);
        nv = next_val(0, 1);
        set_pins(0, nv);
        for (int k = 0; k < 2; k++) model_accept(k, 0, nv, 1'b0);
        tick(5);
        chk("latency_early", int'(up_a[0]), 0);
        tick(1);
        chk("latency_step", int'(up_a[0]), 1);
        tick(4);
        check_all("fwd4");
        chk("fwd4_pos0", get_pos(0, 0), 29);
        chk("fwd4_pos1", get_pos(0, 1), 28);

        // Clamp at POS_MIN
        snap = npulse[0][1][1];
        count(1, -1, 100, 5);
        check_all("clamp");
        chk("clamp_pulses", npulse[0][1][1] - snap, 23);
        chk("clamp_pos", get_pos(0, 1), 5);
        count(1, 1, 4, 5);
        check_all("unclamp");
        chk("unclamp_pos", get_pos(0, 1), 6);

        // Glitch filter
        glitch(0, cur[0] ^ 2'b10, 2);
        check_all("glitch2");
        snap = npulse[1][0][0] + npulse[1][0][1];
        step_pins(0, cur[0] ^ 2'b10, 3);
        step_pins(0, cur[0] ^ 2'b10, 8);
        check_all("glitch3");
        chk("glitch3_taken", npulse[1][0][0] + npulse[1][0][1] - snap, 2);

        // Illegal transitions and clr_err priority
        step_pins(0, 2'b11, 8);
        check_all("illegal");
        chk("illegal_err", int'(err_a[0]), 1);
        set_pins(0, 2'b00);
        for (int k = 0; k < 2; k++) model_accept(k, 0, 2'b00, 1'b0);
        tick(5);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("err_set_beats_clr", int'(err_a[0]), 1);
        tick(4);
        check_all("illegal2");
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 2; c++) m_err[k][c] = 0;
        check_all("clr");

        // reset_game landing on a step request
        reset_game = 1'b1;
        tick(1);
        reset_game = 1'b0;
        model_rg();
        check_all("rg0");
        count(0, 1, 3, 5);
        nv = next_val(0, 1);
        set_pins(0, nv);
        for (int k = 0; k < 2; k++) model_accept(k, 0, nv, 1'b1);
        snap = npulse[0][0][0];
        tick(5);
        reset_game = 1'b1;
        tick(1);
        chk("rg_no_pulse", int'(up_a[0]), 0);
        chk("rg_pos", get_pos(0, 0), c_init);
        reset_game = 1'b0;
        model_rg();
        tick(4);
        check_all("rg1");
        count(0, 1, 3, 5);
        check_all("rg3");
        chk("rg_sub_cleared", npulse[0][0][0] - snap, 0);
        count(0, 1, 1, 5);
        check_all("rg4");
        chk("rg_one_step", npulse[0][0][0] - snap, 1);

        // Randomised motion, glitches and illegal jumps
        for (int it = 0; it < 200; it++) begin
            ch = int'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 11));
            if (r == 0)
                step_pins(ch, cur[ch] ^ 2'b11, int'($urandom_range(3, 8)));
            else if (r == 1)
                glitch(ch, cur[ch] ^ 2'($urandom_range(1, 3)), int'($urandom_range(1, 2)));
            else
                count(ch, (r < 7) ? 1 : -1, 1, int'($urandom_range(3, 8)));
            if (it % 50 == 49) check_all("rand");
        end

        // Priming from a non-zero rest position
        snap2 = total_pulses();
        do_reset(2'b11);
        check_all("prime");
        chk("prime_no_pulse", total_pulses() - snap2, 0);
        count(0, 1, 1, 8);
        count(1, 1, 1, 8);
        check_all("inv");
        chk("inv_pos_b0", get_pos(1, 0), 27);
        chk("inv_pos_b1", get_pos(1, 1), 29);
        chk("inv_pos_a0", get_pos(0, 0), 28);
        step_pins(1, cur[1] ^ 2'b11, 8);
        check_all("pre_rst");

        // Asynchronous reset in the middle of a transition
        set_pins(0, next_val(0, 1));
        tick(3);
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 2; c++) begin
                chk("async_rst_pos", get_pos(k, c), c_init);
                chk("async_rst_err", get_err(k, c), 0);
                chk("async_rst_step", get_up(k, c) + get_dn(k, c), 0);
            end
        model_reset();
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
